// File: rtl/inst_queue.sv
// In-order decoded-instruction queue between decode and issue.
// The head entry is presented every cycle and is popped when issue accepts it.
module inst_queue #(
  parameter int         DEPTH   = 8,
  parameter int         PTR_W   = 3,
  parameter logic [4:0] OP_NONE = 5'd0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [4:0]        in_op,
  input  logic              in_branch,
  input  logic              in_ls,
  input  logic              in_use_imm,
  input  logic              in_jalr,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic [31:0]       in_addr,
  output logic [4:0]        op,
  output logic              branch,
  output logic              ls,
  output logic              use_imm,
  output logic              jalr,
  output logic [4:0]        rd,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [31:0]       imm,
  output logic [31:0]       addr,
  output logic              inst_valid,
  input  logic              launch_fail,
  input  logic              lsb_launch_fail,
  output logic [PTR_W:0]    count
);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] imm;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic        jalr;
    logic        use_imm;
    logic        ls;
    logic        branch;
    logic [4:0]  op;
  } rec_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  rec_t             mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_fire_s;
  logic             pop_fire_s;
  rec_t             wr_rec_s;
  rec_t             head_rec_s;
  rec_t             out_rec_s;

  assign inst_valid = (count_q != {(PTR_W+1){1'b0}});
  // Readiness comes from the registered count only, so a full queue refuses a push even while popping.
  assign push_ready = (count_q != FULL_CNT);
  assign count      = count_q;

  assign push_fire_s = rdy_in & push_valid & push_ready & (in_op != OP_NONE) & ~flush;
  assign pop_fire_s  = rdy_in & inst_valid & ~launch_fail & ~lsb_launch_fail & ~flush;

  assign wr_rec_s = '{addr: in_addr, imm: in_imm, rs2: in_rs2, rs1: in_rs1, rd: in_rd,
                      jalr: in_jalr, use_imm: in_use_imm, ls: in_ls, branch: in_branch,
                      op: in_op};

  // Next-state pointers and occupancy; flush wins over push and pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = {PTR_W{1'b0}};
      tail_d  = {PTR_W{1'b0}};
      count_d = {(PTR_W+1){1'b0}};
    end else begin
      if (push_fire_s) begin
        tail_d = tail_q + PTR_W'(1);
      end else begin
        tail_d = tail_q;
      end
      if (pop_fire_s) begin
        head_d = head_q + PTR_W'(1);
      end else begin
        head_d = head_q;
      end
      count_d = count_q + (PTR_W+1)'(push_fire_s) - (PTR_W+1)'(pop_fire_s);
    end
  end

  // Pointer and count registers; rdy_in low freezes them.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {(PTR_W+1){1'b0}};
    end else if (rdy_in) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk_in) begin
    if (push_fire_s) begin
      mem_q[tail_q] <= wr_rec_s;
    end
  end

  assign head_rec_s = mem_q[head_q];

  // Head presentation; an empty queue shows a bubble.
  always_comb begin
    out_rec_s    = '0;
    out_rec_s.op = OP_NONE;
    if (inst_valid) begin
      out_rec_s = head_rec_s;
    end else begin
      out_rec_s    = '0;
      out_rec_s.op = OP_NONE;
    end
  end

  assign op      = out_rec_s.op;
  assign branch  = out_rec_s.branch;
  assign ls      = out_rec_s.ls;
  assign use_imm = out_rec_s.use_imm;
  assign jalr    = out_rec_s.jalr;
  assign rd      = out_rec_s.rd;
  assign rs1     = out_rec_s.rs1;
  assign rs2     = out_rec_s.rs2;
  assign imm     = out_rec_s.imm;
  assign addr    = out_rec_s.addr;

endmodule
